// File: rtl/button_pulse_gen_multi.sv
// button_pulse_gen_multi
//
// Multi-channel push-button front end. Each channel synchronises a raw
// button level, debounces it, and emits a one-cycle pulse on every press.
// Channels with repeat enabled also emit auto-repeat pulses while held.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous reset, active-high
//   i_push_button  raw asynchronous button levels, 1 = pressed
//   i_repeat_en    per-channel auto-repeat enable (synchronous)
//   o_held         debounced button level
//   o_pulse        one-cycle pulse per press and per repeat
//   o_any_pulse    OR of all o_pulse bits, aligned with o_pulse

`timescale 1ns / 1ps

module button_pulse_gen_multi #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_push_button,
    input  logic [N_BTN-1:0] i_repeat_en,
    output logic [N_BTN-1:0] o_held,
    output logic [N_BTN-1:0] o_pulse,
    output logic             o_any_pulse
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StDelay  = 2'd2;
    localparam logic [1:0] StRepeat = 2'd3;

    // Counters compare against (N-1) so an event lands exactly N edges after
    // the count starts at zero.
    localparam logic [CNT_W-1:0] DbLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RdLast  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RpLast  = CNT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] held_q;
    logic [N_BTN-1:0] held_d;
    logic [N_BTN-1:0] pulse_q;
    logic [N_BTN-1:0] pulse_d;
    logic             any_pulse_q;

    for (genvar k = 0; k < N_BTN; k++) begin : g_ch
        logic [CNT_W-1:0] db_cnt_q;
        logic [CNT_W-1:0] db_cnt_d;
        logic [CNT_W-1:0] rep_cnt_q;
        logic [CNT_W-1:0] rep_cnt_d;
        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic             held_nx;
        logic             pulse_nx;
        logic             rise;
        logic             fall;

        // Debouncer: count consecutive cycles where the synchronised level
        // disagrees with the accepted level; accept after DEBOUNCE_CYCLES.
        always_comb begin
            held_nx  = held_q[k];
            db_cnt_d = '0;
            if (sync2_q[k] != held_q[k]) begin
                if (db_cnt_q == DbLast) begin
                    held_nx = sync2_q[k];
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // The FSM reacts to the debounced edge in the same cycle it is
        // accepted, so the press pulse lines up with the o_held rise.
        assign rise = held_nx & ~held_q[k];
        assign fall = ~held_nx & held_q[k];

        always_comb begin
            state_d   = state_q;
            rep_cnt_d = rep_cnt_q;
            pulse_nx  = 1'b0;
            if (fall) begin
                // Release wins over any repeat pulse due this cycle.
                state_d   = StIdle;
                rep_cnt_d = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (rise) begin
                            pulse_nx  = 1'b1;
                            rep_cnt_d = '0;
                            state_d   = i_repeat_en[k] ? StDelay : StHold;
                        end
                    end
                    StHold: begin
                        rep_cnt_d = '0;
                    end
                    StDelay, StRepeat: begin
                        if (!i_repeat_en[k]) begin
                            state_d   = StHold;
                            rep_cnt_d = '0;
                        end else if (rep_cnt_q == ((state_q == StDelay) ? RdLast : RpLast)) begin
                            pulse_nx  = 1'b1;
                            rep_cnt_d = '0;
                            state_d   = StRepeat;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d   = StIdle;
                        rep_cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                db_cnt_q  <= '0;
                rep_cnt_q <= '0;
                state_q   <= StIdle;
            end else begin
                db_cnt_q  <= db_cnt_d;
                rep_cnt_q <= rep_cnt_d;
                state_q   <= state_d;
            end
        end

        assign held_d[k]  = held_nx;
        assign pulse_d[k] = pulse_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            held_q      <= '0;
            pulse_q     <= '0;
            any_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= i_push_button;
            sync2_q     <= sync1_q;
            held_q      <= held_d;
            pulse_q     <= pulse_d;
            any_pulse_q <= |pulse_d;
        end
    end

    assign o_held      = held_q;
    assign o_pulse     = pulse_q;
    assign o_any_pulse = any_pulse_q;

endmodule

// File: tb/tb_button_pulse_gen_multi.sv
// tb_button_pulse_gen_multi
//
// Bench for button_pulse_gen_multi. Drives directed presses followed by
// random button/enable/reset activity and compares every cycle against a
// behavioural model built from sample windows and absolute pulse schedules.

`timescale 1ns / 1ps

module tb_button_pulse_gen_multi;

    localparam int unsigned NB = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] ren = '0;
    logic [NB-1:0] held;
    logic [NB-1:0] pulse;
    logic          any_pulse;

    int n_vec = 0;
    int n_err = 0;

    button_pulse_gen_multi #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_push_button(btn),
        .i_repeat_en  (ren),
        .o_held       (held),
        .o_pulse      (pulse),
        .o_any_pulse  (any_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit     m_s1   [NB];
    bit     m_s2   [NB];
    bit     m_held [NB];
    bit     m_pulse[NB];
    bit     m_rep  [NB];
    longint m_due  [NB];
    bit     m_win  [NB][$];
    longint edge_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] pack(input bit v[NB]);
        logic [NB-1:0] r;
        for (int k = 0; k < NB; k++) r[k] = v[k];
        return r;
    endfunction

    // Behaviour at one rising edge given the inputs sampled at that edge.
    task automatic model_step(input logic [NB-1:0] b, input logic [NB-1:0] e, input logic r);
        bit synced;
        bit prev;
        bit all_diff;
        edge_n++;
        for (int k = 0; k < NB; k++) begin
            if (r) begin
                m_s1[k] = 0; m_s2[k] = 0; m_held[k] = 0;
                m_pulse[k] = 0; m_rep[k] = 0;
                m_win[k].delete();
            end else begin
                synced  = m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = b[k];
                prev    = m_held[k];
                // Accept a new level once the last DB synchronised samples
                // all disagree with the current accepted level.
                m_win[k].push_back(synced);
                if (m_win[k].size() > DB) void'(m_win[k].pop_front());
                all_diff = (m_win[k].size() == DB);
                foreach (m_win[k][i]) if (m_win[k][i] == m_held[k]) all_diff = 0;
                if (all_diff) begin
                    m_held[k] = ~m_held[k];
                    m_win[k].delete();
                end
                m_pulse[k] = 0;
                if (m_held[k] && !prev) begin
                    m_pulse[k] = 1;
                    m_rep[k]   = e[k];
                    m_due[k]   = edge_n + RD;
                end else if (!m_held[k] && prev) begin
                    m_rep[k] = 0;
                end else if (m_rep[k]) begin
                    if (!e[k]) begin
                        m_rep[k] = 0;
                    end else if (edge_n == m_due[k]) begin
                        m_pulse[k] = 1;
                        m_due[k]   = m_due[k] + RP;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic [NB-1:0] b, input logic [NB-1:0] e, input logic r);
        @(negedge clk);
        btn = b;
        ren = e;
        rst = r;
        @(posedge clk);
        model_step(b, e, r);
        #1;
        check_eq("held", 32'(held), 32'(pack(m_held)));
        check_eq("pulse", 32'(pulse), 32'(pack(m_pulse)));
        check_eq("any_pulse", 32'(any_pulse), 32'(|pack(m_pulse)));
    endtask

    logic [NB-1:0] lvl;
    int            remain[NB];
    logic [NB-1:0] en_r;

    initial begin
        // Reset
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        check_eq("reset_held", 32'(held), 32'h0);
        check_eq("reset_pulse", 32'(pulse), 32'h0);

        // Ch0 and ch3 pressed at the same edge, no repeat: absolute latency.
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1001, 4'b0000, 1'b0);
            check_eq("dir_held", 32'(held), (i >= int'(DB) + 1) ? 32'h9 : 32'h0);
            check_eq("dir_pulse", 32'(pulse), (i == int'(DB) + 1) ? 32'h9 : 32'h0);
            check_eq("dir_any", 32'(any_pulse), (i == int'(DB) + 1) ? 32'h1 : 32'h0);
        end
        // Release: held drops DB+1 edges later with no pulse.
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0000, 4'b0000, 1'b0);
            check_eq("rel_held", 32'(held), (i >= int'(DB) + 1) ? 32'h0 : 32'h9);
            check_eq("rel_pulse", 32'(pulse), 32'h0);
        end

        // Ch2 with repeat: press pulse at edge P, repeats at P+10, +13, +16, ...
        for (int i = 0; i < 30; i++) begin
            cycle(4'b0100, 4'b0100, 1'b0);
            if (i == int'(DB) + 1 || i == int'(DB) + 1 + int'(RD) ||
                i == int'(DB) + 1 + int'(RD) + int'(RP) ||
                i == int'(DB) + 1 + int'(RD) + 2 * int'(RP))
                check_eq("rep_pulse", 32'(pulse), 32'h4);
        end
        // Reset while held, then a fresh press after normal latency.
        cycle(4'b0100, 4'b0100, 1'b1);
        check_eq("rst_mid_held", 32'(held), 32'h0);
        cycle(4'b0100, 4'b0100, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0100, 4'b0100, 1'b0);
            check_eq("rst_fresh_pulse", 32'(pulse), (i == int'(DB) + 1) ? 32'h4 : 32'h0);
        end
        // Drop repeat enable while held: no more pulses.
        cycle(4'b0100, 4'b0000, 1'b0);
        for (int i = 0; i < 25; i++) begin
            cycle(4'b0100, 4'b0100, 1'b0);
            check_eq("ren_drop_pulse", 32'(pulse), 32'h0);
            check_eq("ren_drop_held", 32'(held), 32'h4);
        end

        // Random activity: bursts of bounce and long holds, enable toggles,
        // occasional resets.
        lvl  = '0;
        en_r = 4'b1100;
        for (int k = 0; k < NB; k++) remain[k] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NB; k++) begin
                if (remain[k] == 0) begin
                    lvl[k] = $urandom_range(0, 1);
                    remain[k] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 5))
                                                           : int'($urandom_range(6, 45));
                end
                remain[k]--;
                if ($urandom_range(0, 39) == 0) en_r[k] = ~en_r[k];
            end
            cycle(lvl, en_r, ($urandom_range(0, 599) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
